// File: rtl/pll_seq_ctrl_if.sv
// Control/status bundle between the PLL sequencer and its surroundings.
// The slave side is the sequencer; the master side is the top level (or a bench).
interface pll_seq_ctrl_if #(
    parameter int NUM_OUT = 4
);
    logic               start;
    logic [NUM_OUT-1:0] out_en_mask;
    logic               pll_lock;
    logic               pll_pllen;
    logic               pll_resetn;
    logic [NUM_OUT-1:0] pll_clkout_en;
    logic               ready;
    logic               fail;
    logic [7:0]         relock_cnt;
    logic [2:0]         state;

    modport slave (
        input  start, out_en_mask, pll_lock,
        output pll_pllen, pll_resetn, pll_clkout_en, ready, fail, relock_cnt, state
    );

    modport master (
        output start, out_en_mask, pll_lock,
        input  pll_pllen, pll_resetn, pll_clkout_en, ready, fail, relock_cnt, state
    );
endinterface

// File: rtl/pll_seq_ctrl.sv
// Power-up / relock sequencer for the PLL: drives pllen, resetn and the output clock
// enables, waits for a debounced lock, retries on timeout and relocks on lock loss.
module pll_seq_ctrl #(
    parameter int NUM_OUT      = 4,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 256,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 16
) (
    input  logic           clkin,
    input  logic           resetn,
    pll_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    logic [1:0]         lock_sync_q;
    logic               lock_s;

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   timer_q,  timer_d;
    logic [3:0]         retry_q,  retry_d;
    logic [7:0]         relock_q, relock_d;
    logic [3:0]         retry_inc;

    logic               pllen_q,  pllen_d;
    logic               prstn_q,  prstn_d;
    logic [NUM_OUT-1:0] clk_en_q, clk_en_d;
    logic               ready_q,  ready_d;
    logic               fail_q,   fail_d;

    assign lock_s    = lock_sync_q[1];
    assign retry_inc = retry_q + 4'd1;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            lock_sync_q <= 2'b00;
        end else begin
            lock_sync_q <= {lock_sync_q[0], bus.pll_lock};
        end
    end

    // Next-state, timer, retry and relock bookkeeping; dropping start overrides everything.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        if (!bus.start) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RESET;
                    timer_d = '0;
                    retry_d = 4'd0;
                end
                ST_RESET: begin
                    if (timer_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock takes precedence over a timeout on the same cycle.
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        timer_d = '0;
                        if (retry_inc == RETRY_LIMIT) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_RESET;
                        end
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        timer_d = '0;
                        retry_d = 4'd0;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d  = ST_RESET;
                        timer_d  = '0;
                        relock_d = (relock_q == 8'hFF) ? 8'hFF : (relock_q + 8'd1);
                    end else begin
                        timer_d = '0;
                    end
                end
                ST_FAIL: begin
                    timer_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so registered outputs move with the state register.
    always_comb begin
        pllen_d  = 1'b0;
        prstn_d  = 1'b0;
        clk_en_d = '0;
        ready_d  = 1'b0;
        fail_d   = 1'b0;
        case (state_d)
            ST_IDLE: begin
                pllen_d = 1'b0;
            end
            ST_RESET: begin
                pllen_d = 1'b1;
            end
            ST_WAIT_LOCK, ST_STABLE: begin
                pllen_d = 1'b1;
                prstn_d = 1'b1;
            end
            ST_RUN: begin
                pllen_d  = 1'b1;
                prstn_d  = 1'b1;
                ready_d  = 1'b1;
                clk_en_d = bus.out_en_mask;
            end
            ST_FAIL: begin
                fail_d = 1'b1;
            end
            default: begin
                pllen_d = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset forces every PLL control low at once.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            retry_q  <= 4'd0;
            relock_q <= 8'd0;
            pllen_q  <= 1'b0;
            prstn_q  <= 1'b0;
            clk_en_q <= '0;
            ready_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            relock_q <= relock_d;
            pllen_q  <= pllen_d;
            prstn_q  <= prstn_d;
            clk_en_q <= clk_en_d;
            ready_q  <= ready_d;
            fail_q   <= fail_d;
        end
    end

    assign bus.pll_pllen     = pllen_q;
    assign bus.pll_resetn    = prstn_q;
    assign bus.pll_clkout_en = clk_en_q;
    assign bus.ready         = ready_q;
    assign bus.fail          = fail_q;
    assign bus.relock_cnt    = relock_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Scenario bench for pll_seq_ctrl: a timeline model predicts every state change
// (cycle number and outputs); a monitor compares each observed change against it.
module tb_pll_seq_ctrl;

    localparam int NUM_OUT      = 4;
    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRY    = 2;
    localparam int CNT_W        = 16;
    localparam int ATTEMPT      = RST_CYCLES + LOCK_TIMEOUT;
    localparam int SYNC_LAT     = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pll_seq_ctrl_if #(.NUM_OUT(NUM_OUT)) bus ();

    pll_seq_ctrl #(
        .NUM_OUT(NUM_OUT), .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE(LOCK_STABLE), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
    ) dut (
        .clkin (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    typedef struct {
        int         c;
        logic [2:0] st;
        logic       pllen;
        logic       rstn;
        logic [3:0] en;
        logic       rdy;
        logic       fl;
        logic [7:0] rl;
    } ev_t;

    ev_t expq[$];
    int  total = 0;
    int  bad   = 0;
    int  rl_m  = 0;

    function automatic void chk(input string nm, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cyc %0d)", nm, got, exp, cyc);
        end
    endfunction

    // Expected outputs for a given state come from the output table of the sequencer.
    function automatic void push(input int c, input int st, input logic [3:0] en);
        ev_t e;
        e.c     = c;
        e.st    = 3'(st);
        e.pllen = (st >= 1 && st <= 4);
        e.rstn  = (st >= 2 && st <= 4);
        e.en    = en;
        e.rdy   = (st == 4);
        e.fl    = (st == 5);
        e.rl    = 8'(rl_m);
        expq.push_back(e);
    endfunction

    // Monitor: every visible state change must match the next predicted event.
    initial begin
        logic [2:0] prev;
        ev_t        e;
        prev = 3'd0;
        forever begin
            @(negedge clk);
            if (bus.state !== prev) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: state got=%0d at cyc %0d, none expected", bus.state, cyc);
                end else begin
                    e = expq.pop_front();
                    chk("ev_cycle", cyc, e.c);
                    chk("ev_state", bus.state, e.st);
                    chk("ev_ctrl", {bus.pll_pllen, bus.pll_resetn, bus.ready, bus.fail},
                        {e.pllen, e.rstn, e.rdy, e.fl});
                    chk("ev_clkout_en", bus.pll_clkout_en, e.en);
                    chk("ev_relock_cnt", bus.relock_cnt, e.rl);
                end
                prev = bus.state;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // WAIT_LOCK entered at w; lock raised L cycles later and held.
    task automatic lock_phase(input int w, input int l, input logic [3:0] m);
        int a;
        a = w + l;
        push(w, 2, 4'd0);
        push(a + SYNC_LAT + 1, 3, 4'd0);
        push(a + SYNC_LAT + 1 + LOCK_STABLE, 4, m);
        goto(a);
        bus.pll_lock = 1'b1;
        goto(a + SYNC_LAT + 2 + LOCK_STABLE);
    endtask

    // Lock high for h cycles, low for one, then high for good.
    task automatic bounce_phase(input int w, input int l, input int h, input logic [3:0] m);
        int a;
        a = w + l;
        push(w, 2, 4'd0);
        push(a + SYNC_LAT + 1, 3, 4'd0);
        push(a + h + SYNC_LAT + 1, 2, 4'd0);
        push(a + h + SYNC_LAT + 2, 3, 4'd0);
        push(a + h + SYNC_LAT + 2 + LOCK_STABLE, 4, m);
        goto(a);
        bus.pll_lock = 1'b1;
        goto(a + h);
        bus.pll_lock = 1'b0;
        goto(a + h + 1);
        bus.pll_lock = 1'b1;
        goto(a + h + SYNC_LAT + 3 + LOCK_STABLE);
    endtask

    // From IDLE: nfail timed-out attempts, then either FAIL or a lock (optionally bouncing).
    task automatic bring_up(input logic [3:0] m, input int l, input int nfail, input int h);
        int t;
        bus.out_en_mask = m;
        bus.pll_lock    = 1'b0;
        bus.start       = 1'b1;
        t = cyc + 1;
        push(t, 1, 4'd0);
        for (int k = 0; k < nfail; k++) begin
            push(t + RST_CYCLES, 2, 4'd0);
            push(t + ATTEMPT, (k + 1 == MAX_RETRY) ? 5 : 1, 4'd0);
            t = t + ATTEMPT;
        end
        if (nfail >= MAX_RETRY) goto(t + 2);
        else if (h == 0) lock_phase(t + RST_CYCLES, l, m);
        else bounce_phase(t + RST_CYCLES, l, h, m);
    endtask

    task automatic stop();
        push(cyc + 1, 0, 4'd0);
        bus.start    = 1'b0;
        bus.pll_lock = 1'b0;
        goto(cyc + 4);
    endtask

    task automatic lose_lock(input int l, input logic [3:0] m);
        int r;
        r = cyc + SYNC_LAT + 1;
        rl_m = (rl_m == 255) ? 255 : rl_m + 1;
        push(r, 1, 4'd0);
        bus.pll_lock = 1'b0;
        goto(cyc + 1);
        chk("loss_still_en", bus.pll_clkout_en, m);
        goto(r);
        chk("loss_en_dropped", bus.pll_clkout_en, 0);
        lock_phase(r + RST_CYCLES, l, m);
    endtask

    initial begin
        logic [3:0] m;
        int         a, w;
        bus.start       = 1'b0;
        bus.out_en_mask = 4'd0;
        bus.pll_lock    = 1'b0;

        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_ctrl", {bus.pll_pllen, bus.pll_resetn, bus.ready, bus.fail}, 0);
        chk("rst_clkout_en", bus.pll_clkout_en, 0);
        chk("rst_relock_cnt", bus.relock_cnt, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        goto(cyc + 2);

        // Nominal bring-up, lock five cycles after release, then mask follows in RUN.
        bring_up(4'b0011, 5, 0, 0);
        chk("nominal_ready", bus.ready, 1);
        chk("nominal_en", bus.pll_clkout_en, 4'b0011);
        for (int i = 0; i < 2; i++) begin
            m = 4'($urandom);
            bus.out_en_mask = m;
            goto(cyc + 1);
            chk("mask_follow", bus.pll_clkout_en, m);
        end
        stop();

        // Random bring-ups, some with one timed-out attempt first.
        for (int i = 0; i < 4; i++) begin
            bring_up(4'($urandom), $urandom_range(0, 17), $urandom_range(0, 1), 0);
            chk("rand_ready", bus.ready, 1);
            stop();
        end

        // Two timeouts reach FAIL; dropping start returns to IDLE.
        bring_up(4'b1111, 0, MAX_RETRY, 0);
        chk("fail_flag", bus.fail, 1);
        chk("fail_pllen", bus.pll_pllen, 0);
        chk("fail_state", bus.state, 5);
        stop();
        chk("fail_to_idle", bus.state, 0);

        // Lock bounce in STABLE, after one timeout so a counted bounce would cause FAIL.
        bring_up(4'b0101, 4, 1, 5);
        chk("bounce_ready", bus.ready, 1);
        stop();
        bring_up(4'b1001, 2, 0, $urandom_range(1, 8));
        stop();

        // Lock reaches lock_s exactly on the last WAIT_LOCK cycle.
        bring_up(4'b0110, LOCK_TIMEOUT - 1 - SYNC_LAT, 1, 0);
        chk("simul_ready", bus.ready, 1);

        // Three lock losses in RUN.
        for (int i = 0; i < 3; i++) lose_lock($urandom_range(0, 10), 4'b0110);
        chk("relock_three", bus.relock_cnt, 3);

        // start dropped while in STABLE.
        stop();
        bus.pll_lock = 1'b0;
        bus.start    = 1'b1;
        push(cyc + 1, 1, 4'd0);
        w = cyc + 1 + RST_CYCLES;
        push(w, 2, 4'd0);
        a = w + 3;
        push(a + SYNC_LAT + 1, 3, 4'd0);
        goto(a);
        bus.pll_lock = 1'b1;
        goto(a + SYNC_LAT + 3);
        push(cyc + 1, 0, 4'd0);
        bus.start = 1'b0;
        goto(cyc + 1);
        chk("stable_stop_pllen", bus.pll_pllen, 0);
        chk("stable_stop_state", bus.state, 0);
        bus.pll_lock = 1'b0;
        goto(cyc + 3);

        // Asynchronous reset while in RUN clears everything immediately.
        bring_up(4'b1111, 1, 0, 0);
        #2;
        resetn = 1'b0;
        rl_m   = 0;
        #1;
        chk("arst_state", bus.state, 0);
        chk("arst_ctrl", {bus.pll_pllen, bus.pll_resetn, bus.ready, bus.fail}, 0);
        chk("arst_clkout_en", bus.pll_clkout_en, 0);
        chk("arst_relock_cnt", bus.relock_cnt, 0);
        push(cyc + 1, 0, 4'd0);
        bus.start    = 1'b0;
        bus.pll_lock = 1'b0;
        @(negedge clk);
        #2;
        resetn = 1'b1;
        goto(cyc + 3);

        // Saturation of the relock counter.
        bring_up(4'b1010, 0, 0, 0);
        for (int i = 0; i < 256; i++) lose_lock(0, 4'b1010);
        chk("relock_saturated", bus.relock_cnt, 255);
        stop();

        goto(cyc + 5);
        chk("events_consumed", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
